// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared types for the back-end fe_queue buffer
package bp_be_pkg;

   // Per-pointer update selected by the pointer controller each cycle
   typedef enum logic [1:0] {
      e_ptr_hold,
      e_ptr_inc,
      e_ptr_load
   } bp_fe_queue_ptr_op_e;

   // Pointer width: slot index plus one wrap bit to tell full from empty
   function automatic int fe_queue_ptr_width(input int els);
      return $clog2(els) + 1;
   endfunction

endpackage

// File: rtl/bp_be_fe_queue_ptr_ctrl.sv
// rtl/bp_be_fe_queue_ptr_ctrl.sv - write/read/commit pointer controller
module bp_be_fe_queue_ptr_ctrl
   import bp_be_pkg::*;
#(
   parameter int els_p = 8,
   localparam int ptr_width_lp = fe_queue_ptr_width(els_p),
   localparam int idx_width_lp = ptr_width_lp - 1
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    enq_i,
   input  logic                    yumi_i,
   input  logic                    deq_i,
   input  logic                    roll_i,
   input  logic                    clr_i,
   output logic [ptr_width_lp-1:0] wptr_o,
   output logic [ptr_width_lp-1:0] rptr_o,
   output logic [ptr_width_lp-1:0] cptr_o,
   output logic                    full_o,
   output logic                    empty_o
);

   bp_fe_queue_ptr_op_e wptr_op, rptr_op, cptr_op;
   logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
   logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;

   // Operation select: clr beats roll beats the normal enq/yumi/deq traffic
   always_comb begin
      wptr_op = e_ptr_hold;
      rptr_op = e_ptr_hold;
      cptr_op = e_ptr_hold;
      if (clr_i) begin
         wptr_op = e_ptr_load;
         rptr_op = e_ptr_load;
         cptr_op = e_ptr_load;
      end else begin
         if (enq_i) wptr_op = e_ptr_inc;
         if (deq_i) cptr_op = e_ptr_inc;
         if (roll_i) rptr_op = e_ptr_load;
         else if (yumi_i) rptr_op = e_ptr_inc;
      end
   end

   // Next-pointer values; rptr reloads from the post-deq commit point on roll
   always_comb begin
      wptr_n = wptr_r;
      cptr_n = cptr_r;
      rptr_n = rptr_r;
      unique case (wptr_op)
         e_ptr_inc:  wptr_n = wptr_r + 1'b1;
         e_ptr_load: wptr_n = '0;
         default:    wptr_n = wptr_r;
      endcase
      unique case (cptr_op)
         e_ptr_inc:  cptr_n = cptr_r + 1'b1;
         e_ptr_load: cptr_n = '0;
         default:    cptr_n = cptr_r;
      endcase
      unique case (rptr_op)
         e_ptr_inc:  rptr_n = rptr_r + 1'b1;
         e_ptr_load: rptr_n = clr_i ? '0 : cptr_n;
         default:    rptr_n = rptr_r;
      endcase
   end

   // Pointer registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_r <= '0;
         rptr_r <= '0;
         cptr_r <= '0;
      end else begin
         wptr_r <= wptr_n;
         rptr_r <= rptr_n;
         cptr_r <= cptr_n;
      end
   end

   assign wptr_o  = wptr_r;
   assign rptr_o  = rptr_r;
   assign cptr_o  = cptr_r;
   assign full_o  = (wptr_r[idx_width_lp-1:0] == cptr_r[idx_width_lp-1:0])
                  & (wptr_r[idx_width_lp] != cptr_r[idx_width_lp]);
   assign empty_o = (wptr_r == cptr_r);

endmodule

// File: rtl/bsg_mem_1r1w.sv
// rtl/bsg_mem_1r1w.sv - one-write one-async-read register-file storage
module bsg_mem_1r1w #(
   parameter int width_p = 8,
   parameter int els_p = 8,
   localparam int addr_width_lp = $clog2(els_p)
) (
   input  logic                     w_clk_i,
   input  logic                     w_v_i,
   input  logic [addr_width_lp-1:0] w_addr_i,
   input  logic [width_p-1:0]       w_data_i,
   input  logic [addr_width_lp-1:0] r_addr_i,
   output logic [width_p-1:0]       r_data_o
);

   logic [width_p-1:0] mem_r [els_p];

   // Write port; contents are not reset, stale slots are never presented as valid
   always_ff @(posedge w_clk_i) begin
      if (w_v_i) begin
         mem_r[w_addr_i] <= w_data_i;
      end
   end

   assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_be_fe_queue_buffer.sv
// rtl/bp_be_fe_queue_buffer.sv - replayable fe_queue buffer; BP_FE_QUEUE_BYPASS_EN adds a zero-cycle enqueue bypass
module bp_be_fe_queue_buffer
   import bp_be_pkg::*;
#(
   parameter int els_p = 8,
   parameter int entry_width_p = 140,
   localparam int ptr_width_lp = fe_queue_ptr_width(els_p),
   localparam int idx_width_lp = ptr_width_lp - 1
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [entry_width_p-1:0] fe_queue_i,
   input  logic                     fe_queue_v_i,
   output logic                     fe_queue_ready_o,
   output logic [entry_width_p-1:0] fe_queue_o,
   output logic                     fe_queue_v_o,
   input  logic                     fe_queue_yumi_i,
   input  logic                     deq_i,
   input  logic                     roll_i,
   input  logic                     clr_i,
   output logic                     empty_o
);

   logic [ptr_width_lp-1:0]  wptr, rptr, cptr;
   logic                     full, enq, unread;
   logic [entry_width_p-1:0] mem_data;

   assign fe_queue_ready_o = ~full & ~clr_i;
   assign enq              = fe_queue_v_i & fe_queue_ready_o;
   assign unread           = (rptr != wptr);

   bp_be_fe_queue_ptr_ctrl #(
      .els_p (els_p)
   ) ptr_ctrl (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .enq_i   (enq),
      .yumi_i  (fe_queue_yumi_i),
      .deq_i   (deq_i),
      .roll_i  (roll_i),
      .clr_i   (clr_i),
      .wptr_o  (wptr),
      .rptr_o  (rptr),
      .cptr_o  (cptr),
      .full_o  (full),
      .empty_o (empty_o)
   );

   bsg_mem_1r1w #(
      .width_p (entry_width_p),
      .els_p   (els_p)
   ) store (
      .w_clk_i  (clk_i),
      .w_v_i    (enq),
      .w_addr_i (wptr[idx_width_lp-1:0]),
      .w_data_i (fe_queue_i),
      .r_addr_i (rptr[idx_width_lp-1:0]),
      .r_data_o (mem_data)
   );

`ifdef BP_FE_QUEUE_BYPASS_EN
   // Nothing unread: hand the incoming packet straight through while it is also stored
   logic bypass;
   assign bypass       = ~unread & enq & ~roll_i;
   assign fe_queue_v_o = (unread | bypass) & ~roll_i & ~clr_i;
   assign fe_queue_o   = bypass ? fe_queue_i : mem_data;
`else
   assign fe_queue_v_o = unread & ~roll_i & ~clr_i;
   assign fe_queue_o   = mem_data;
`endif

`ifndef SYNTHESIS
   yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
      (fe_queue_yumi_i & ~roll_i & ~clr_i) |-> fe_queue_v_o);
   deq_behind_read: assert property (@(posedge clk_i) disable iff (reset_i)
      (deq_i & ~clr_i) |-> (cptr != rptr));
   enq_needs_space: assert property (@(posedge clk_i) disable iff (reset_i)
      enq |-> ~full);
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
// tb/tb_bp_be_fe_queue_buffer.sv - self-checking bench for bp_be_fe_queue_buffer (honours BP_FE_QUEUE_BYPASS_EN)
module tb_bp_be_fe_queue_buffer;

   localparam int W = 140;
   localparam int N = 8;
`ifdef BP_FE_QUEUE_BYPASS_EN
   localparam int byp = 1;
`else
   localparam int byp = 0;
`endif

   logic         clk_i = 1'b0;
   logic         reset_i;
   logic [W-1:0] fe_queue_i;
   logic         fe_queue_v_i;
   logic         fe_queue_ready_o;
   logic [W-1:0] fe_queue_o;
   logic         fe_queue_v_o;
   logic         fe_queue_yumi_i;
   logic         deq_i;
   logic         roll_i;
   logic         clr_i;
   logic         empty_o;

   bp_be_fe_queue_buffer #(.els_p(N), .entry_width_p(W)) dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .fe_queue_i       (fe_queue_i),
      .fe_queue_v_i     (fe_queue_v_i),
      .fe_queue_ready_o (fe_queue_ready_o),
      .fe_queue_o       (fe_queue_o),
      .fe_queue_v_o     (fe_queue_v_o),
      .fe_queue_yumi_i  (fe_queue_yumi_i),
      .deq_i            (deq_i),
      .roll_i           (roll_i),
      .clr_i            (clr_i),
      .empty_o          (empty_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int           v, yumi, deq, roll, clr;
      logic [W-1:0] d;
      int           e_ready, e_v, e_empty;
      logic [W-1:0] e_data;
   } vec_t;

   vec_t         tbl[$];
   logic [W-1:0] held[$];
   int           rd = 0;
   int           checks = 0;
   int           failures = 0;

   function automatic vec_t mk(input int v, input logic [W-1:0] d, input int y, input int dq,
                               input int rl, input int cl, input int er, input int ev,
                               input logic [W-1:0] ed, input int ee);
      vec_t t;
      t.v = v; t.d = d; t.yumi = y; t.deq = dq; t.roll = rl; t.clr = cl;
      t.e_ready = er; t.e_v = ev; t.e_data = ed; t.e_empty = ee;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input int v, input logic [W-1:0] d, input int y, input int dq,
                        input int rl, input int cl);
      fe_queue_v_i    = (v != 0);
      fe_queue_i      = d;
      fe_queue_yumi_i = (y != 0);
      deq_i           = (dq != 0);
      roll_i          = (rl != 0);
      clr_i           = (cl != 0);
   endtask

   task automatic model_update(input int v, input logic [W-1:0] d, input int y, input int dq,
                               input int rl, input int cl);
      if (cl != 0) begin
         held.delete();
         rd = 0;
      end else begin
         if (v != 0 && held.size() < N) held.push_back(d);
         if (dq != 0) begin
            void'(held.pop_front());
            rd--;
         end
         if (rl != 0) rd = 0;
         else if (y != 0) rd++;
      end
   endtask

   // One cycle checked against the scoreboard model
   task automatic rstep(input string tag, input int v, input logic [W-1:0] d, input int y,
                        input int dq, input int rl, input int cl);
      int           e_ready, e_v;
      logic [W-1:0] e_data;
      drive(v, d, y, dq, rl, cl);
      #1;
      e_ready = (held.size() < N && cl == 0) ? 1 : 0;
      e_v = 0;
      e_data = '0;
      if (rd < held.size()) begin
         e_v = 1;
         e_data = held[rd];
      end else if (byp != 0 && v != 0 && e_ready != 0) begin
         e_v = 1;
         e_data = d;
      end
      if (rl != 0 || cl != 0) e_v = 0;
      chk({tag, " ready"}, W'(fe_queue_ready_o), W'(e_ready));
      chk({tag, " v_o"}, W'(fe_queue_v_o), W'(e_v));
      if (e_v != 0) chk({tag, " data"}, fe_queue_o, e_data);
      chk({tag, " empty"}, W'(empty_o), W'(held.size() == 0));
      model_update(v, d, y, dq, rl, cl);
      @(negedge clk_i);
   endtask

   function automatic logic [W-1:0] rnd();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return t[W-1:0];
   endfunction

   initial begin
      vec_t t;
      int   n, m, k;
      // Fill/drain: packets 1..8, one refused while full, then drain in order
      for (int i = 1; i <= N; i++)
         tbl.push_back(mk(1, W'(i), 0, 0, 0, 0, 1, (i == 1) ? byp : 1, W'(1), (i == 1) ? 1 : 0));
      tbl.push_back(mk(1, W'(9), 0, 0, 0, 0, 0, 1, W'(1), 0));
      tbl.push_back(mk(0, '0, 1, 0, 0, 0, 0, 1, W'(1), 0));
      for (int j = 2; j <= N; j++)
         tbl.push_back(mk(0, '0, 1, 1, 0, 0, (j == 2) ? 0 : 1, 1, W'(j), 0));
      tbl.push_back(mk(0, '0, 0, 1, 0, 0, 1, 0, '0, 0));
      tbl.push_back(mk(0, '0, 0, 0, 0, 0, 1, 0, '0, 1));
      // Roll: A,B,C in; read A,B; commit A; roll back to B
      tbl.push_back(mk(1, W'(32'hA1), 0, 0, 0, 0, 1, byp, W'(32'hA1), 1));
      tbl.push_back(mk(1, W'(32'hB2), 0, 0, 0, 0, 1, 1, W'(32'hA1), 0));
      tbl.push_back(mk(1, W'(32'hC3), 0, 0, 0, 0, 1, 1, W'(32'hA1), 0));
      tbl.push_back(mk(0, '0, 1, 0, 0, 0, 1, 1, W'(32'hA1), 0));
      tbl.push_back(mk(0, '0, 1, 0, 0, 0, 1, 1, W'(32'hB2), 0));
      tbl.push_back(mk(0, '0, 0, 1, 0, 0, 1, 1, W'(32'hC3), 0));
      tbl.push_back(mk(0, '0, 0, 0, 1, 0, 1, 0, '0, 0));
      tbl.push_back(mk(0, '0, 1, 0, 0, 0, 1, 1, W'(32'hB2), 0));
      tbl.push_back(mk(0, '0, 1, 0, 0, 0, 1, 1, W'(32'hC3), 0));
      tbl.push_back(mk(0, '0, 0, 1, 0, 0, 1, 0, '0, 0));
      tbl.push_back(mk(0, '0, 0, 1, 0, 0, 1, 0, '0, 0));
      tbl.push_back(mk(0, '0, 0, 0, 0, 0, 1, 0, '0, 1));
      // Roll and deq together: A,B read, deq+roll re-presents B
      tbl.push_back(mk(1, W'(32'hA1), 0, 0, 0, 0, 1, byp, W'(32'hA1), 1));
      tbl.push_back(mk(1, W'(32'hB2), 0, 0, 0, 0, 1, 1, W'(32'hA1), 0));
      tbl.push_back(mk(0, '0, 1, 0, 0, 0, 1, 1, W'(32'hA1), 0));
      tbl.push_back(mk(0, '0, 1, 0, 0, 0, 1, 1, W'(32'hB2), 0));
      tbl.push_back(mk(0, '0, 0, 1, 1, 0, 1, 0, '0, 0));
      tbl.push_back(mk(0, '0, 1, 0, 0, 0, 1, 1, W'(32'hB2), 0));
      tbl.push_back(mk(0, '0, 0, 1, 0, 0, 1, 0, '0, 0));
      tbl.push_back(mk(0, '0, 0, 0, 0, 0, 1, 0, '0, 1));

      drive(0, '0, 0, 0, 0, 0);
      reset_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
      #1;
      chk("reset ready", W'(fe_queue_ready_o), W'(1));
      chk("reset v_o", W'(fe_queue_v_o), W'(0));
      chk("reset empty", W'(empty_o), W'(1));
      @(negedge clk_i);

      foreach (tbl[i]) begin
         t = tbl[i];
         drive(t.v, t.d, t.yumi, t.deq, t.roll, t.clr);
         #1;
         chk($sformatf("vec%0d ready", i), W'(fe_queue_ready_o), W'(t.e_ready));
         chk($sformatf("vec%0d v_o", i), W'(fe_queue_v_o), W'(t.e_v));
         if (t.e_v != 0) chk($sformatf("vec%0d data", i), fe_queue_o, t.e_data);
         chk($sformatf("vec%0d empty", i), W'(empty_o), W'(t.e_empty));
         model_update(t.v, t.d, t.yumi, t.deq, t.roll, t.clr);
         @(negedge clk_i);
      end

      // Clear with concurrent enqueue and yumi, then a fresh packet
      for (int i = 0; i < 5; i++) rstep("clr_fill", 1, W'(32'h10 + i), 0, 0, 0, 0);
      rstep("clr_rd", 0, '0, 1, 0, 0, 0);
      rstep("clr_rd", 0, '0, 1, 0, 0, 0);
      rstep("clr", 1, W'(32'hEE), 1, 0, 0, 1);
      rstep("clr_enq", 1, W'(32'hAA), 0, 0, 0, 0);
      rstep("clr_out", 0, '0, 1, 0, 0, 0);
      rstep("clr_deq", 0, '0, 0, 1, 0, 0);

      // Bypass / latency on an empty buffer, then replay of the same entry
`ifdef BP_FE_QUEUE_BYPASS_EN
      rstep("byp_enq", 1, W'(32'h55), 1, 0, 0, 0);
`else
      rstep("byp_enq", 1, W'(32'h55), 0, 0, 0, 0);
      rstep("byp_yumi", 0, '0, 1, 0, 0, 0);
`endif
      rstep("byp_roll", 0, '0, 0, 0, 1, 0);
      rstep("byp_replay", 0, '0, 1, 0, 0, 0);
      rstep("byp_deq", 0, '0, 0, 1, 0, 0);

      // Wrap: varying occupancy across many pointer laps
      for (int r = 0; r < 20; r++) begin
         n = (r % 5 == 0) ? (N - held.size()) : $urandom_range(0, N - held.size());
         repeat (n) rstep("wrap_enq", 1, rnd(), 0, 0, 0, 0);
         rstep("wrap_try", 1, rnd(), 0, 0, 0, 0);
         m = (r % 4 == 3) ? (held.size() - rd) : $urandom_range(0, held.size() - rd);
         repeat (m) rstep("wrap_yumi", 0, '0, 1, 0, 0, 0);
         k = (r % 4 == 3) ? rd : $urandom_range(0, rd);
         repeat (k) rstep("wrap_deq", 0, '0, 0, 1, 0, 0);
      end

      // Reset mid-operation drops held entries
      for (int i = 0; i < 3; i++) rstep("rst_fill", 1, W'(32'h30 + i), 0, 0, 0, 0);
      drive(0, '0, 0, 0, 0, 0);
      reset_i = 1'b1;
      @(negedge clk_i);
      reset_i = 1'b0;
      held.delete();
      rd = 0;
      #1;
      chk("rst_mid ready", W'(fe_queue_ready_o), W'(1));
      chk("rst_mid v_o", W'(fe_queue_v_o), W'(0));
      chk("rst_mid empty", W'(empty_o), W'(1));
      @(negedge clk_i);
      rstep("rst_enq", 1, W'(32'h77), 0, 0, 0, 0);
      rstep("rst_out", 0, '0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
